// File: rtl/complete_datapath_pkg.sv
// Shared encodings for the 16-bit RISC datapath: mux selects, ALU ops, opcodes.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package complete_datapath_pkg;

  // PC source select
  localparam logic [1:0] PC_SEL_ADD   = 2'b00;
  localparam logic [1:0] PC_SEL_ALU   = 2'b01;
  localparam logic [1:0] PC_SEL_LABEL = 2'b10;
  localparam logic [1:0] PC_SEL_AREG  = 2'b11;

  // Immediate select
  localparam logic [1:0] IMM_ZEXT5  = 2'b00;
  localparam logic [1:0] IMM_ZEXT8  = 2'b01;
  localparam logic [1:0] IMM_SEXT8  = 2'b10;
  localparam logic [1:0] IMM_HI_LO  = 2'b11;

  // ALU B operand select
  localparam logic [1:0] ALUB_BREG = 2'b00;
  localparam logic [1:0] ALUB_IMM  = 2'b01;
  localparam logic [1:0] ALUB_ONE  = 2'b10;
  localparam logic [1:0] ALUB_ZERO = 2'b11;

  // Register file write data select
  localparam logic [1:0] RFW_ALU = 2'b00;
  localparam logic [1:0] RFW_MEM = 2'b01;
  localparam logic [1:0] RFW_IMM = 2'b10;
  localparam logic [1:0] RFW_PC  = 2'b11;

  // ALU operations, encoded as IR[1:0]
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_ADC = 2'b01,
    ALU_SUB = 2'b10,
    ALU_SBB = 2'b11
  } alu_op_e;

  // Opcodes, IR[15:11]
  localparam logic [4:0] OP_LHI  = 5'b00001;
  localparam logic [4:0] OP_LLI  = 5'b00010;
  localparam logic [4:0] OP_SUBI = 5'b01000;
  localparam logic [4:0] OP_JMP  = 5'b10000;

endpackage

// File: rtl/complete_datapath_alu.sv
// dp_alu: 16-bit adder/subtractor with carry-in, producing result, carry and zero.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b operands; op ALU operation; cin carry flag; result, c (carry-out bit 15), z.
module dp_alu
  import complete_datapath_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  alu_op_e     op,
  input  logic        cin,
  output logic [15:0] result,
  output logic        c,
  output logic        z
);

  logic [15:0] b_eff;
  logic        carry_in;
  logic [16:0] sum;

  // Subtracts add the complement; C=1 therefore means "no borrow".
  always_comb begin
    b_eff    = b;
    carry_in = 1'b0;
    case (op)
      ALU_ADD: begin b_eff = b;  carry_in = 1'b0; end
      ALU_ADC: begin b_eff = b;  carry_in = cin;  end
      ALU_SUB: begin b_eff = ~b; carry_in = 1'b1; end
      ALU_SBB: begin b_eff = ~b; carry_in = cin;  end
      default: begin b_eff = b;  carry_in = 1'b0; end
    endcase
  end

  assign sum    = {1'b0, a} + {1'b0, b_eff} + {16'h0000, carry_in};
  assign result = sum[15:0];
  assign c      = sum[16];
  assign z      = (sum[15:0] == 16'h0000);

endmodule

// File: rtl/complete_datapath.sv
// Datapath of the multi-cycle 16-bit RISC: PC, IR, unified memory, 8x16 regfile, ALU, flags, Out_R.
// Latency: every register loads on the rising edge when its enable is set; memory read is combinational.
// Backpressure: none; all enables and selects come from the external controller.
// Ports: control inputs (PC_*, Mem*, Rd_Rm_Sel, Imm_Sel, ALU_*, *_CE, RF_*), decoded IR fields out,
// Imm_Out, Mem_Data_Reg, Z_Reg, C_Reg, Out_R. Optional macro EXT_MEM_READ_EN adds Ext_Mem_Rd_Data.
module complete_datapath
  import complete_datapath_pkg::*;
#(
  parameter int MEM_AW = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_CE,
  input  logic [1:0]  PC_Sel,
  input  logic        PC_Add_Src,
  input  logic        PC_ALU_Sel,
  input  logic        Mem_Addr_Sel,
  input  logic [15:0] Ext_Mem_Addr,
  input  logic        MemW_Data_Sel,
  input  logic [15:0] Ext_MemW_Data,
  input  logic        MemW_en,
  input  logic        Rd_Rm_Sel,
  input  logic [1:0]  Imm_Sel,
  input  logic        ALU_A_Sel,
  input  logic [1:0]  ALU_B_Sel,
  input  logic        ALU_Control,
  input  logic        ALUOut_Reg_CE,
  input  logic        Z_CE,
  input  logic        C_CE,
  input  logic        Rd_Reg_CE,
  input  logic        RF_Write_en,
  input  logic [1:0]  RF_Write_Data_Sel,
  input  logic        Out_R_CE,
  output logic [4:0]  Opcode,
  output logic [2:0]  Rd_Addr,
  output logic [2:0]  Rm_Addr,
  output logic [2:0]  Rn_Addr,
  output logic [1:0]  ALU_Op,
  output logic [10:0] PC_Label11,
  output logic [15:0] Imm_Out,
  output logic [15:0] Mem_Data_Reg,
  output logic        Z_Reg,
  output logic        C_Reg,
  output logic [15:0] Out_R
`ifdef EXT_MEM_READ_EN
  ,
  output logic [15:0] Ext_Mem_Rd_Data
`endif
);

  logic [15:0] pc;
  logic [15:0] ir;
  logic [15:0] a_reg;
  logic [15:0] b_reg;
  logic [15:0] rd_reg;
  logic [15:0] alu_out_reg;
  logic [15:0] rf [8];
  logic [15:0] mem [2**MEM_AW];

  logic [15:0]       mem_addr;
  logic [MEM_AW-1:0] mem_idx;
  logic [15:0]       mem_rd;
  logic [15:0]       mem_wdata;
  logic [2:0]        a_addr;
  logic [15:0]       pc_next;
  logic [15:0]       alu_a;
  logic [15:0]       alu_b;
  alu_op_e           alu_op;
  logic [15:0]       alu_result;
  logic              alu_c;
  logic              alu_z;
  logic [15:0]       rf_wdata;
  logic              unused_addr_bits;

  // Decoded instruction fields
  assign Opcode     = ir[15:11];
  assign Rd_Addr    = ir[10:8];
  assign Rm_Addr    = ir[7:5];
  assign Rn_Addr    = ir[4:2];
  assign ALU_Op     = ir[1:0];
  assign PC_Label11 = ir[10:0];

  // Memory addressing: only the low MEM_AW bits index the array.
  assign mem_addr         = Mem_Addr_Sel ? Ext_Mem_Addr : (PC_ALU_Sel ? alu_out_reg : pc);
  assign mem_idx          = mem_addr[MEM_AW-1:0];
  assign unused_addr_bits = ^mem_addr[15:MEM_AW];
  assign mem_rd           = mem[mem_idx];
  assign mem_wdata        = MemW_Data_Sel ? Ext_MemW_Data : rd_reg;

`ifdef EXT_MEM_READ_EN
  assign Ext_Mem_Rd_Data = mem_rd;
`endif

  // Memory is not reset; read-during-write sees the old word because the read is
  // taken combinationally before the edge commits the write.
  always_ff @(posedge clk) begin
    if (MemW_en) mem[mem_idx] <= mem_wdata;
  end

  assign a_addr = Rd_Rm_Sel ? Rd_Addr : Rm_Addr;

  always_comb begin
    Imm_Out = 16'h0000;
    case (Imm_Sel)
      IMM_ZEXT5: Imm_Out = {11'h000, ir[4:0]};
      IMM_ZEXT8: Imm_Out = {8'h00, ir[7:0]};
      IMM_SEXT8: Imm_Out = {{8{ir[7]}}, ir[7:0]};
      IMM_HI_LO: Imm_Out = {ir[7:0], rd_reg[7:0]};
      default:   Imm_Out = 16'h0000;
    endcase
  end

  always_comb begin
    pc_next = pc + (PC_Add_Src ? Imm_Out : 16'h0001);
    case (PC_Sel)
      PC_SEL_ADD:   pc_next = pc + (PC_Add_Src ? Imm_Out : 16'h0001);
      PC_SEL_ALU:   pc_next = alu_out_reg;
      PC_SEL_LABEL: pc_next = {pc[15:11], ir[10:0]};
      PC_SEL_AREG:  pc_next = a_reg;
      default:      pc_next = pc;
    endcase
  end

  // ALU operand and operation selection; with ALU_Control low only SUBI subtracts.
  assign alu_a  = ALU_A_Sel ? pc : a_reg;
  assign alu_op = ALU_Control ? alu_op_e'(ALU_Op) : ((Opcode == OP_SUBI) ? ALU_SUB : ALU_ADD);

  always_comb begin
    alu_b = b_reg;
    case (ALU_B_Sel)
      ALUB_BREG: alu_b = b_reg;
      ALUB_IMM:  alu_b = Imm_Out;
      ALUB_ONE:  alu_b = 16'h0001;
      ALUB_ZERO: alu_b = 16'h0000;
      default:   alu_b = b_reg;
    endcase
  end

  dp_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .cin    (C_Reg),
    .result (alu_result),
    .c      (alu_c),
    .z      (alu_z)
  );

  always_comb begin
    rf_wdata = alu_out_reg;
    case (RF_Write_Data_Sel)
      RFW_ALU: rf_wdata = alu_out_reg;
      RFW_MEM: rf_wdata = Mem_Data_Reg;
      RFW_IMM: rf_wdata = Imm_Out;
      RFW_PC:  rf_wdata = pc;
      default: rf_wdata = alu_out_reg;
    endcase
  end

  // Fetch path: PC, IR and the per-cycle memory data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= 16'h0000;
      ir           <= 16'h0000;
      Mem_Data_Reg <= 16'h0000;
    end else begin
      if (PC_CE) pc <= pc_next;
      if (PC_CE && (PC_Sel == PC_SEL_ADD)) ir <= mem_rd;
      Mem_Data_Reg <= mem_rd;
    end
  end

  // Register file and operand/result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
      a_reg       <= 16'h0000;
      b_reg       <= 16'h0000;
      rd_reg      <= 16'h0000;
      alu_out_reg <= 16'h0000;
      Z_Reg       <= 1'b0;
      C_Reg       <= 1'b0;
      Out_R       <= 16'h0000;
    end else begin
      a_reg <= rf[a_addr];
      b_reg <= rf[Rn_Addr];
      if (Rd_Reg_CE)     rd_reg      <= rf[a_addr];
      if (Out_R_CE)      Out_R       <= rf[a_addr];
      if (ALUOut_Reg_CE) alu_out_reg <= alu_result;
      if (Z_CE)          Z_Reg       <= alu_z;
      if (C_CE)          C_Reg       <= alu_c;
      if (RF_Write_en)   rf[Rd_Addr] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_complete_datapath.sv
module tb_complete_datapath;

  logic        clk;
  logic        rst_n;
  logic        PC_CE;
  logic [1:0]  PC_Sel;
  logic        PC_Add_Src;
  logic        PC_ALU_Sel;
  logic        Mem_Addr_Sel;
  logic [15:0] Ext_Mem_Addr;
  logic        MemW_Data_Sel;
  logic [15:0] Ext_MemW_Data;
  logic        MemW_en;
  logic        Rd_Rm_Sel;
  logic [1:0]  Imm_Sel;
  logic        ALU_A_Sel;
  logic [1:0]  ALU_B_Sel;
  logic        ALU_Control;
  logic        ALUOut_Reg_CE;
  logic        Z_CE;
  logic        C_CE;
  logic        Rd_Reg_CE;
  logic        RF_Write_en;
  logic [1:0]  RF_Write_Data_Sel;
  logic        Out_R_CE;
  logic [4:0]  Opcode;
  logic [2:0]  Rd_Addr;
  logic [2:0]  Rm_Addr;
  logic [2:0]  Rn_Addr;
  logic [1:0]  ALU_Op;
  logic [10:0] PC_Label11;
  logic [15:0] Imm_Out;
  logic [15:0] Mem_Data_Reg;
  logic        Z_Reg;
  logic        C_Reg;
  logic [15:0] Out_R;

  int vectors;
  int miscompares;

  complete_datapath #(.MEM_AW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .PC_CE(PC_CE), .PC_Sel(PC_Sel), .PC_Add_Src(PC_Add_Src), .PC_ALU_Sel(PC_ALU_Sel),
    .Mem_Addr_Sel(Mem_Addr_Sel), .Ext_Mem_Addr(Ext_Mem_Addr),
    .MemW_Data_Sel(MemW_Data_Sel), .Ext_MemW_Data(Ext_MemW_Data), .MemW_en(MemW_en),
    .Rd_Rm_Sel(Rd_Rm_Sel), .Imm_Sel(Imm_Sel), .ALU_A_Sel(ALU_A_Sel), .ALU_B_Sel(ALU_B_Sel),
    .ALU_Control(ALU_Control), .ALUOut_Reg_CE(ALUOut_Reg_CE), .Z_CE(Z_CE), .C_CE(C_CE),
    .Rd_Reg_CE(Rd_Reg_CE), .RF_Write_en(RF_Write_en), .RF_Write_Data_Sel(RF_Write_Data_Sel),
    .Out_R_CE(Out_R_CE),
    .Opcode(Opcode), .Rd_Addr(Rd_Addr), .Rm_Addr(Rm_Addr), .Rn_Addr(Rn_Addr),
    .ALU_Op(ALU_Op), .PC_Label11(PC_Label11), .Imm_Out(Imm_Out),
    .Mem_Data_Reg(Mem_Data_Reg), .Z_Reg(Z_Reg), .C_Reg(C_Reg), .Out_R(Out_R)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    PC_CE = 0; PC_Sel = 2'b00; PC_Add_Src = 0; PC_ALU_Sel = 0;
    Mem_Addr_Sel = 0; Ext_Mem_Addr = 16'h0; MemW_Data_Sel = 0; Ext_MemW_Data = 16'h0;
    MemW_en = 0; Rd_Rm_Sel = 0; Imm_Sel = 2'b00; ALU_A_Sel = 0; ALU_B_Sel = 2'b00;
    ALU_Control = 0; ALUOut_Reg_CE = 0; Z_CE = 0; C_CE = 0; Rd_Reg_CE = 0;
    RF_Write_en = 0; RF_Write_Data_Sel = 2'b00; Out_R_CE = 0;
  endtask

  task automatic mem_wr(input logic [15:0] addr, input logic [15:0] data);
    idle();
    Mem_Addr_Sel = 1; Ext_Mem_Addr = addr; MemW_Data_Sel = 1; Ext_MemW_Data = data; MemW_en = 1;
    tick();
    idle();
  endtask

  // Loads IR from an arbitrary address (PC advances by one as a side effect).
  task automatic fetch_ext(input logic [15:0] addr);
    idle();
    Mem_Addr_Sel = 1; Ext_Mem_Addr = addr; PC_CE = 1; PC_Sel = 2'b00;
    tick();
    idle();
  endtask

  // Writes mem[addr] into R[Rd] through Mem_Data_Reg, then refreshes A_Reg (port A = Rm).
  task automatic load_rd_from_mem(input logic [15:0] addr);
    idle();
    Mem_Addr_Sel = 1; Ext_Mem_Addr = addr;
    tick();
    idle();
    RF_Write_Data_Sel = 2'b01; RF_Write_en = 1;
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    tick(); tick();
    vectors++; if (Out_R !== 16'h0) begin miscompares++; $display("FAIL reset_out_r: got %h want 0000", Out_R); end
    vectors++; if (dut.pc !== 16'h0) begin miscompares++; $display("FAIL reset_pc: got %h want 0000", dut.pc); end
    vectors++; if ({Z_Reg, C_Reg} !== 2'b00) begin miscompares++; $display("FAIL reset_flags: got %b want 00", {Z_Reg, C_Reg}); end
    vectors++; if (Opcode !== 5'b0 || Mem_Data_Reg !== 16'h0) begin miscompares++; $display("FAIL reset_ir_mdr: got %b/%h want 00000/0000", Opcode, Mem_Data_Reg); end
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_fetch_lli();
    mem_wr(16'h0000, 16'h1025);
    // Fetch from PC=0
    PC_CE = 1; PC_Sel = 2'b00; PC_Add_Src = 0;
    tick();
    idle();
    vectors++; if (Opcode !== 5'b00010) begin miscompares++; $display("FAIL fetch_opcode: got %b want 00010", Opcode); end
    vectors++; if (dut.pc !== 16'h0001) begin miscompares++; $display("FAIL fetch_pc: got %h want 0001", dut.pc); end
    vectors++; if ({Rd_Addr, Rm_Addr, Rn_Addr, ALU_Op} !== {3'd0, 3'd1, 3'd1, 2'd1}) begin
      miscompares++; $display("FAIL fetch_fields: got %0d %0d %0d %0d want 0 1 1 1", Rd_Addr, Rm_Addr, Rn_Addr, ALU_Op); end
    Imm_Sel = 2'b01; #1;
    vectors++; if (Imm_Out !== 16'h0025) begin miscompares++; $display("FAIL lli_imm: got %h want 0025", Imm_Out); end
    RF_Write_Data_Sel = 2'b10; RF_Write_en = 1;
    tick();
    idle();
    Rd_Rm_Sel = 1; Out_R_CE = 1;
    tick();
    idle();
    vectors++; if (Out_R !== 16'h0025) begin miscompares++; $display("FAIL lli_out_r: got %h want 0025", Out_R); end
  endtask

  task automatic test_lhi();
    mem_wr(16'h0002, 16'h0863);   // LHI R0,#0x63
    fetch_ext(16'h0002);
    vectors++; if (Opcode !== 5'b00001) begin miscompares++; $display("FAIL lhi_opcode: got %b want 00001", Opcode); end
    Rd_Rm_Sel = 1; Rd_Reg_CE = 1;
    tick();
    idle();
    Imm_Sel = 2'b11; #1;
    vectors++; if (Imm_Out !== 16'h6325) begin miscompares++; $display("FAIL lhi_imm: got %h want 6325", Imm_Out); end
    RF_Write_Data_Sel = 2'b10; RF_Write_en = 1;
    tick();
    idle();
    Rd_Rm_Sel = 1; Out_R_CE = 1;
    tick();
    idle();
    vectors++; if (Out_R !== 16'h6325) begin miscompares++; $display("FAIL lhi_out_r: got %h want 6325", Out_R); end
  endtask

  task automatic test_alu_flags();
    mem_wr(16'h0010, 16'hFFFF);
    mem_wr(16'h0011, 16'h0001);
    mem_wr(16'h0012, 16'h0005);
    mem_wr(16'h0020, 16'h0122);   // Rd=1 Rm=1 imm5=2 op=SUB
    mem_wr(16'h0022, 16'h0123);   // imm5=3 op=SBB
    mem_wr(16'h0023, 16'h0121);   // imm5=1 op=ADC
    mem_wr(16'h0024, 16'h4123);   // SUBI imm5=3
    fetch_ext(16'h0020);
    vectors++; if (ALU_Op !== 2'b10 || Rd_Addr !== 3'd1) begin miscompares++; $display("FAIL alu_ir_fields: got op %b rd %0d want 10 1", ALU_Op, Rd_Addr); end

    // ADD 0xFFFF + 1
    load_rd_from_mem(16'h0010);
    ALU_B_Sel = 2'b10; ALUOut_Reg_CE = 1; Z_CE = 1; C_CE = 1;
    tick();
    idle();
    vectors++; if ({dut.alu_out_reg, Z_Reg, C_Reg} !== {16'h0000, 1'b1, 1'b1}) begin
      miscompares++; $display("FAIL add_wrap: got %h Z%b C%b want 0000 Z1 C1", dut.alu_out_reg, Z_Reg, C_Reg); end

    // SUB 1 - 2
    load_rd_from_mem(16'h0011);
    ALU_Control = 1; ALU_B_Sel = 2'b01; Imm_Sel = 2'b00; ALUOut_Reg_CE = 1; Z_CE = 1; C_CE = 1;
    tick();
    idle();
    vectors++; if ({dut.alu_out_reg, Z_Reg, C_Reg} !== {16'hFFFF, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL sub_borrow: got %h Z%b C%b want ffff Z0 C0", dut.alu_out_reg, Z_Reg, C_Reg); end

    // SBB 5 - 3 with C=0
    fetch_ext(16'h0022);
    load_rd_from_mem(16'h0012);
    ALU_Control = 1; ALU_B_Sel = 2'b01; Imm_Sel = 2'b00; ALUOut_Reg_CE = 1; Z_CE = 1; C_CE = 1;
    tick();
    idle();
    vectors++; if ({dut.alu_out_reg, Z_Reg, C_Reg} !== {16'h0001, 1'b0, 1'b1}) begin
      miscompares++; $display("FAIL sbb: got %h Z%b C%b want 0001 Z0 C1", dut.alu_out_reg, Z_Reg, C_Reg); end

    // ADC 5 + 1 + C(1)
    fetch_ext(16'h0023);
    ALU_Control = 1; ALU_B_Sel = 2'b01; Imm_Sel = 2'b00; ALUOut_Reg_CE = 1; Z_CE = 1; C_CE = 1;
    tick();
    idle();
    vectors++; if ({dut.alu_out_reg, Z_Reg, C_Reg} !== {16'h0007, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL adc: got %h Z%b C%b want 0007 Z0 C0", dut.alu_out_reg, Z_Reg, C_Reg); end

    // SUBI selected by opcode with ALU_Control=0: 5 - 3
    fetch_ext(16'h0024);
    ALU_Control = 0; ALU_B_Sel = 2'b01; Imm_Sel = 2'b00; ALUOut_Reg_CE = 1; Z_CE = 1; C_CE = 1;
    tick();
    idle();
    vectors++; if ({dut.alu_out_reg, Z_Reg, C_Reg} !== {16'h0002, 1'b0, 1'b1}) begin
      miscompares++; $display("FAIL subi: got %h Z%b C%b want 0002 Z0 C1", dut.alu_out_reg, Z_Reg, C_Reg); end
  endtask

  task automatic test_load_store();
    mem_wr(16'h0040, 16'h0047);
    mem_wr(16'h0041, 16'hDEAD);
    mem_wr(16'h0030, 16'h1234);
    mem_wr(16'h0025, 16'h0340);   // Rd=3 Rm=2 imm8=0x40
    mem_wr(16'h0026, 16'h0341);   // Rd=3 Rm=2 imm8=0x41
    fetch_ext(16'h0025);
    load_rd_from_mem(16'h0030);   // R3 = 0x1234
    Rd_Rm_Sel = 1; Rd_Reg_CE = 1;
    tick();
    idle();
    vectors++; if (dut.rd_reg !== 16'h1234) begin miscompares++; $display("FAIL rd_reg_load: got %h want 1234", dut.rd_reg); end
    tick();                       // A_Reg back to R2 (zero)
    ALU_B_Sel = 2'b01; Imm_Sel = 2'b01; ALUOut_Reg_CE = 1;
    tick();
    idle();
    PC_ALU_Sel = 1;
    tick();
    vectors++; if (Mem_Data_Reg !== 16'h0047) begin miscompares++; $display("FAIL load_0x40: got %h want 0047", Mem_Data_Reg); end
    fetch_ext(16'h0026);
    ALU_B_Sel = 2'b01; Imm_Sel = 2'b01; ALUOut_Reg_CE = 1;
    tick();
    idle();
    PC_ALU_Sel = 1; MemW_Data_Sel = 0; MemW_en = 1;
    tick();
    vectors++; if (Mem_Data_Reg !== 16'hDEAD) begin miscompares++; $display("FAIL store_read_old: got %h want dead", Mem_Data_Reg); end
    idle();
    PC_ALU_Sel = 1;
    tick();
    idle();
    vectors++; if (Mem_Data_Reg !== 16'h1234) begin miscompares++; $display("FAIL store_readback: got %h want 1234", Mem_Data_Reg); end
  endtask

  task automatic test_branch_jump();
    mem_wr(16'h0027, 16'h801D);   // JMP 0x01D
    mem_wr(16'h0028, 16'hC304);   // branch disp +4
    mem_wr(16'h001D, 16'hC3FE);   // branch disp -2
    mem_wr(16'h0021, 16'h800A);   // JMP 0x00A
    fetch_ext(16'h0027);
    PC_Sel = 2'b10; PC_CE = 1;
    tick();
    idle();
    vectors++; if (dut.pc !== 16'h001D) begin miscompares++; $display("FAIL jmp_1d: got %h want 001d", dut.pc); end
    ALU_A_Sel = 1; ALU_B_Sel = 2'b11; ALUOut_Reg_CE = 1;
    tick();
    fetch_ext(16'h0028);
    PC_Sel = 2'b01; PC_CE = 1;
    tick();
    idle();
    Imm_Sel = 2'b10; #1;
    vectors++; if (Imm_Out !== 16'h0004) begin miscompares++; $display("FAIL sext_pos: got %h want 0004", Imm_Out); end
    PC_Sel = 2'b00; PC_Add_Src = 1; PC_CE = 1;
    tick();
    vectors++; if (dut.pc !== 16'h0021) begin miscompares++; $display("FAIL branch_fwd: got %h want 0021", dut.pc); end
    vectors++; if (Imm_Out !== 16'hFFFE) begin miscompares++; $display("FAIL sext_neg: got %h want fffe", Imm_Out); end
    tick();
    idle();
    vectors++; if (dut.pc !== 16'h001F) begin miscompares++; $display("FAIL branch_back: got %h want 001f", dut.pc); end
    vectors++; if (Opcode !== 5'b10000 || PC_Label11 !== 11'h00A) begin
      miscompares++; $display("FAIL jmp_ir: got %b %h want 10000 00a", Opcode, PC_Label11); end
    PC_Sel = 2'b10; PC_CE = 1;
    tick();
    idle();
    RF_Write_Data_Sel = 2'b11; RF_Write_en = 1;
    tick();
    idle();
    Rd_Rm_Sel = 1; Out_R_CE = 1;
    tick();
    idle();
    vectors++; if (Out_R !== 16'h000A) begin miscompares++; $display("FAIL jmp_pc_to_r0: got %h want 000a", Out_R); end
  endtask

  task automatic test_reset_midrun();
    idle();
    #2;
    rst_n = 0;
    #1;
    vectors++; if (Out_R !== 16'h0) begin miscompares++; $display("FAIL midrst_out_r: got %h want 0000", Out_R); end
    vectors++; if (dut.pc !== 16'h0) begin miscompares++; $display("FAIL midrst_pc: got %h want 0000", dut.pc); end
    vectors++; if ({Z_Reg, C_Reg} !== 2'b00) begin miscompares++; $display("FAIL midrst_flags: got %b want 00", {Z_Reg, C_Reg}); end
    @(negedge clk);
    rst_n = 1;
    Mem_Addr_Sel = 1; Ext_Mem_Addr = 16'h0040;
    tick();
    idle();
    vectors++; if (Mem_Data_Reg !== 16'h0047) begin miscompares++; $display("FAIL mem_kept: got %h want 0047", Mem_Data_Reg); end
    PC_CE = 1;
    tick();
    idle();
    vectors++; if (Opcode !== 5'b00010) begin miscompares++; $display("FAIL refetch_pc0: got %b want 00010", Opcode); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    idle();
    rst_n = 0;
    test_reset();
    test_fetch_lli();
    test_lhi();
    test_alu_flags();
    test_load_store();
    test_branch_jump();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/complete_datapath.md
Name: complete_datapath

Overview:
Datapath of the multi-cycle 16-bit RISC computer. It holds the PC, instruction register, unified instruction/data memory, 8x16 register file, ALU, flags and output register. It has no FSM: every enable and mux select is an input driven by the external controller. Decoded instruction fields are returned to that controller.

Parameters:
MEM_AW, 8, memory address width; 2**MEM_AW 16-bit words; addresses use the low MEM_AW bits.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
PC_CE  in  1  PC load enable; also loads IR when PC_Sel=00
PC_Sel  in  2  PC source: 00 PC adder, 01 ALUOut_Reg, 10 {PC[15:11],PC_Label11}, 11 A_Reg
PC_Add_Src  in  1  PC adder operand: 0 constant 1, 1 Imm_Out
PC_ALU_Sel  in  1  internal memory address: 0 PC, 1 ALUOut_Reg
Mem_Addr_Sel  in  1  1 selects Ext_Mem_Addr over the internal address
Ext_Mem_Addr  in  16  external memory address
MemW_Data_Sel  in  1  memory write data: 0 Rd_Reg, 1 Ext_MemW_Data
Ext_MemW_Data  in  16  external write data
MemW_en  in  1  memory write enable
Rd_Rm_Sel  in  1  read port A address: 0 Rm, 1 Rd
Imm_Sel  in  2  00 zext IR[4:0], 01 zext IR[7:0], 10 sext IR[7:0], 11 {IR[7:0],Rd_Reg[7:0]}
ALU_A_Sel  in  1  ALU A operand: 0 A_Reg, 1 PC
ALU_B_Sel  in  2  ALU B operand: 00 B_Reg, 01 Imm_Out, 10 16'h0001, 11 16'h0000
ALU_Control  in  1  1 ALU op from ALU_Op; 0 ADD, or SUB when Opcode=01000
ALUOut_Reg_CE  in  1  ALUOut_Reg load enable
Z_CE, C_CE  in  1 each  flag load enables
Rd_Reg_CE  in  1  Rd_Reg loads from read port A
RF_Write_en  in  1  register file write enable; write address is Rd
RF_Write_Data_Sel  in  2  00 ALUOut_Reg, 01 Mem_Data_Reg, 10 Imm_Out, 11 PC
Out_R_CE  in  1  Out_R loads from read port A
Opcode  out  5  IR[15:11]
Rd_Addr, Rm_Addr, Rn_Addr  out  3 each  IR[10:8], IR[7:5], IR[4:2]
ALU_Op  out  2  IR[1:0]
PC_Label11  out  11  IR[10:0]
Imm_Out  out  16  immediate mux output
Mem_Data_Reg  out  16  registered memory read data
Z_Reg, C_Reg  out  1 each  flags
Out_R  out  16  output register

Behaviour:
- Async reset (rst_n=0) clears PC, IR, Mem_Data_Reg, A_Reg, B_Reg, Rd_Reg, ALUOut_Reg, Z_Reg, C_Reg, Out_R and all 8 registers. Memory contents are not reset.
- Memory: combinational read and synchronous write on MemW_en. A same-cycle read of the address being written returns the old data.
- Mem_Data_Reg loads the memory read data every cycle.
- IR loads the memory read data when PC_CE=1 and PC_Sel=00.
- Register file: port A address is Rd or Rm (per Rd_Rm_Sel); port B address is Rn. A_Reg and B_Reg load ports A and B every cycle.
- Register file write is synchronous. A read of the register being written returns the old value.
- ALU ops (16-bit): ADD A+B; ADC A+B+C_Reg; SUB A+~B+1; SBB A+~B+C_Reg.
- Flags: C = carry-out of bit 15, so C=1 means no borrow on subtracts. Z = (result==0).
- PC adder: PC + (PC_Add_Src ? Imm_Out : 1), modulo 2^16.
- All register enables are independent. Simultaneous enables all take effect on the same edge.

Optional Feature:
EXT_MEM_READ_EN. When defined, adds output Ext_Mem_Rd_Data [15:0], equal to the combinational memory read data at the selected address, for debug and bench readback. When undefined, the port does not exist and behaviour is otherwise identical.

Decomposition:
- Package complete_datapath_pkg holds:
  - localparams for the PC_Sel, Imm_Sel, ALU_B_Sel and RF_Write_Data_Sel encodings;
  - the ALU op codes;
  - opcode constants (LHI 00001, LLI 00010, SUBI 01000, JMP 10000, ...).
- One sub-module, dp_alu: combinational adder/subtractor producing result, C and Z.

Test Plan:
- Reset and Out_R: assert rst_n=0 mid-run. Out_R, PC and flags go to 0 immediately.
- Fetch and LLI:
  - write mem[0]=0x1025 via Ext (Mem_Addr_Sel=1, MemW_Data_Sel=1, MemW_en=1), then fetch with PC_CE=1, PC_Sel=00 -> Opcode=00010, PC=1;
  - Imm_Sel=01, RF_Write_Data_Sel=10, RF_Write_en -> R0=0x0025, Out_R=0x0025.
- LHI #0x63 with R0=0x0025: Rd_Rm_Sel=1, Rd_Reg_CE=1, then Imm_Sel=11, RF_Write_Data_Sel=10, RF_Write_en -> R0=0x6325.
- ALU flags:
  - ADD 0xFFFF+0x0001 -> 0x0000, Z=1, C=1;
  - SUB 0x0001-0x0002 -> 0xFFFF, C=0, Z=0;
  - SBB 5-3 with C=0 -> 0x0001.
- Load/store: mem[0x40]=0x0047, ALUOut=0x40, PC_ALU_Sel=1 -> Mem_Data_Reg=0x0047; store Rd_Reg=0x1234 to 0x41 -> read back 0x1234.
- Branch and jump:
  - PC=0x1D, IR=0xC304, Imm_Sel=10, PC_Add_Src=1 -> PC=0x21;
  - disp 0xFE -> PC-2;
  - IR=0x800A, PC_Sel=10 -> PC=0x000A.
